// File: rtl/nonce_dispatch_if.sv
// Host/pipeline bundle for nonce_dispatch; issue_rdy exists only with NONCE_DISPATCH_STALL_EN.
// master = dispatcher side, slave = host, hash pipeline and comparator side.
interface nonce_dispatch_if;
  logic        start;
  logic        abort;
  logic [31:0] nonce_first;
  logic [31:0] nonce_last;
  logic [63:0] target_in;
  logic [63:0] target;
  logic        valid;
  logic        vld;
  logic [63:0] m04;
  logic        found;
  logic [31:0] found_nonce;
  logic        res_vld;
  logic        res_rdy;
  logic        res_hit;
  logic [31:0] res_nonce;
  logic        idle;
`ifdef NONCE_DISPATCH_STALL_EN
  logic        issue_rdy;
`endif

  modport master (
`ifdef NONCE_DISPATCH_STALL_EN
    input  issue_rdy,
`endif
    input  start, abort, nonce_first, nonce_last, target_in, found, found_nonce, res_rdy,
    output target, valid, vld, m04, res_vld, res_hit, res_nonce, idle
  );

  modport slave (
`ifdef NONCE_DISPATCH_STALL_EN
    output issue_rdy,
`endif
    output start, abort, nonce_first, nonce_last, target_in, found, found_nonce, res_rdy,
    input  target, valid, vld, m04, res_vld, res_hit, res_nonce, idle
  );
endinterface

// File: rtl/nonce_dispatch.sv
// Walks a (possibly wrapping) nonce range into the hash pipeline, drains PIPE_DEPTH cycles, reports hit/miss.
// Result held until res_rdy; NONCE_DISPATCH_STALL_EN adds issue_rdy backpressure on beats.
module nonce_dispatch #(
  parameter int PIPE_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  nonce_dispatch_if.master bus
);

  localparam int DW = $clog2(PIPE_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [31:0]    r_cnt;
  logic [31:0]    r_last;
  logic [63:0]    r_target;
  logic           r_valid;
  logic [DW-1:0]  r_drain;
  logic           r_res_hit;
  logic [31:0]   r_res_nonce;

  logic           w_acc;
  logic           w_load;
  logic           w_to_drain;
  logic           w_cap_hit;
  logic           w_cap_miss;
  logic [31:0]    w_miss_nonce;
  logic           w_vld;
  logic           w_res_vld;
  logic           w_idle;

`ifdef NONCE_DISPATCH_STALL_EN
  assign w_acc = bus.issue_rdy;
`else
  assign w_acc = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Priority inside RUN/DRAIN: found, then abort, then range end / drain end.
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_to_drain   = 1'b0;
    w_cap_hit    = 1'b0;
    w_cap_miss   = 1'b0;
    w_miss_nonce = r_last;
    w_vld        = 1'b0;
    w_res_vld    = 1'b0;
    w_idle       = 1'b0;
    case (r_state)
      IDLE: begin
        w_idle = 1'b1;
        if (bus.start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_vld = 1'b1;
        if (bus.found) begin
          w_cap_hit = 1'b1;
          w_next    = REPORT;
        end else if (bus.abort) begin
          // A stalled beat was never issued, so the last issued nonce is one behind.
          w_cap_miss   = 1'b1;
          w_miss_nonce = w_acc ? r_cnt : r_cnt - 32'd1;
          w_next       = REPORT;
        end else if (w_acc && (r_cnt == r_last)) begin
          w_to_drain = 1'b1;
          w_next     = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.found) begin
          w_cap_hit = 1'b1;
          w_next    = REPORT;
        end else if (bus.abort || (r_drain <= DW'(1))) begin
          w_cap_miss = 1'b1;
          w_next     = REPORT;
        end
      end
      REPORT: begin
        w_res_vld = 1'b1;
        if (bus.res_rdy) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_last      <= '0;
      r_target    <= '0;
      r_valid     <= 1'b0;
      r_drain     <= '0;
      r_res_hit   <= 1'b0;
      r_res_nonce <= '0;
    end else begin
      r_valid <= w_load;
      if (w_load) begin
        r_cnt    <= bus.nonce_first;
        r_last   <= bus.nonce_last;
        r_target <= bus.target_in;
      end else if ((r_state == RUN) && w_acc) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_to_drain)              r_drain <= DW'(PIPE_DEPTH);
      else if (r_state == DRAIN)   r_drain <= r_drain - DW'(1);
      if (w_cap_hit) begin
        r_res_hit   <= 1'b1;
        r_res_nonce <= bus.found_nonce;
      end else if (w_cap_miss) begin
        r_res_hit   <= 1'b0;
        r_res_nonce <= w_miss_nonce;
      end
    end
  end

  assign bus.vld       = w_vld;
  assign bus.m04       = {32'h0, r_cnt[7:0], r_cnt[15:8], r_cnt[23:16], r_cnt[31:24]};
  assign bus.target    = r_target;
  assign bus.valid     = r_valid;
  assign bus.res_vld   = w_res_vld;
  assign bus.res_hit   = r_res_hit;
  assign bus.res_nonce = r_res_nonce;
  assign bus.idle      = w_idle;

endmodule
